// File: rtl/csr_trap_ctrl_pkg.sv
// Shared encodings for the CSR/trap control stage: opcodes, funct3 values,
// CSR addresses, mcause values and the sequencer state type.
package csr_pkg;

  localparam logic [6:0]  OPC_SYSTEM  = 7'b1110011;
  localparam logic [31:0] INST_UNIMP  = 32'hC000_1073;

  localparam logic [2:0]  F3_PRIV     = 3'b000;
  localparam logic [2:0]  F3_CSRRW    = 3'b001;
  localparam logic [2:0]  F3_CSRRS    = 3'b010;
  localparam logic [2:0]  F3_CSRRC    = 3'b011;
  localparam logic [2:0]  F3_ILLEGAL  = 3'b100;
  localparam logic [2:0]  F3_CSRRWI   = 3'b101;
  localparam logic [2:0]  F3_CSRRSI   = 3'b110;
  localparam logic [2:0]  F3_CSRRCI   = 3'b111;

  localparam logic [11:0] IMM_ECALL   = 12'h000;
  localparam logic [11:0] IMM_EBREAK  = 12'h001;
  localparam logic [11:0] IMM_MRET    = 12'h302;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  localparam logic [31:0] CAUSE_ILLEGAL = 32'h0000_0002;
  localparam logic [31:0] CAUSE_BREAK   = 32'h0000_0003;
  localparam logic [31:0] CAUSE_ECALL_M = 32'h0000_000B;
  localparam logic [31:0] CAUSE_IRQ_EXT = 32'h8000_000B;

  localparam logic [1:0]  OP_NONE     = 2'b00;
  localparam logic [1:0]  OP_RW       = 2'b01;
  localparam logic [1:0]  OP_RS       = 2'b10;
  localparam logic [1:0]  OP_RC       = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_CSR_WB    = 3'd1,
    ST_TRAP_SAVE = 3'd2,
    ST_TRAP_JUMP = 3'd3,
    ST_MRET_JUMP = 3'd4
  } csr_state_t;

  function automatic logic csr_addr_legal(input logic [11:0] addr);
    case (addr)
      CSR_MSTATUS, CSR_MTVEC, CSR_MEPC, CSR_MCAUSE: csr_addr_legal = 1'b1;
      default:                                      csr_addr_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/csr_trap_ctrl_if.sv
// Bundle between the execute stage / CSR file / fetch stage and the CSR trap
// controller; master drives instruction and CSR state, slave is the controller.
interface csr_trap_ctrl_if
  import csr_pkg::*;
;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] pc;
  logic [31:0] rs1_data;
  logic [31:0] csr_rdata;
  logic [31:0] mtvec_in;
  logic [31:0] mepc_in;
  logic        mstatus_mie;
  logic        irq;

  logic [11:0] csr_raddr;
  logic        csr_we;
  logic [11:0] csr_waddr;
  logic [31:0] csr_wdata;
  logic        trap_set;
  logic [31:0] trap_cause;
  logic [31:0] trap_epc;
  logic        mret_clr;
  logic        rd_we;
  logic [4:0]  rd_addr;
  logic [31:0] rd_wdata;
  logic        stall;
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  modport master (
    output inst_valid, inst, pc, rs1_data, csr_rdata, mtvec_in, mepc_in,
           mstatus_mie, irq,
    input  csr_raddr, csr_we, csr_waddr, csr_wdata, trap_set, trap_cause,
           trap_epc, mret_clr, rd_we, rd_addr, rd_wdata, stall, flush,
           redirect_valid, redirect_pc
  );

  modport slave (
    input  inst_valid, inst, pc, rs1_data, csr_rdata, mtvec_in, mepc_in,
           mstatus_mie, irq,
    output csr_raddr, csr_we, csr_waddr, csr_wdata, trap_set, trap_cause,
           trap_epc, mret_clr, rd_we, rd_addr, rd_wdata, stall, flush,
           redirect_valid, redirect_pc
  );

endinterface

// File: rtl/csr_trap_ctrl_wdata_alu.sv
// CSR read-modify-write merge (RW/RS/RC) and the write-enable rule: set/clear
// with a zero rs1/zimm field never writes, and mcause is read-only here.
module csr_wdata_alu
  import csr_pkg::*;
(
  input  logic [1:0]  op_i,
  input  logic [11:0] addr_i,
  input  logic [31:0] old_i,
  input  logic [31:0] src_i,
  input  logic        src_idx_zero_i,
  output logic [31:0] wdata_o,
  output logic        we_o
);

  // Merge old CSR value with the source operand and qualify the write.
  always_comb begin
    wdata_o = 32'h0000_0000;
    we_o    = 1'b0;
    case (op_i)
      OP_RW: begin
        wdata_o = src_i;
        we_o    = 1'b1;
      end
      OP_RS: begin
        wdata_o = old_i | src_i;
        we_o    = !src_idx_zero_i;
      end
      OP_RC: begin
        wdata_o = old_i & ~src_i;
        we_o    = !src_idx_zero_i;
      end
      default: begin
        wdata_o = 32'h0000_0000;
        we_o    = 1'b0;
      end
    endcase
    if (addr_i == CSR_MCAUSE) begin
      we_o = 1'b0;
    end else begin
      we_o = we_o;
    end
  end

endmodule

// File: rtl/csr_trap_ctrl.sv
// SYSTEM-opcode sequencer: CSR read-modify-write, trap entry and MRET.
// Define CSR_TRAP_IRQ_EN to enable the synchronized external interrupt path.
module csr_trap_ctrl
  import csr_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  csr_trap_ctrl_if.slave bus
);

  localparam logic [2:0] S_IDLE      = 3'(ST_IDLE);
  localparam logic [2:0] S_CSR_WB    = 3'(ST_CSR_WB);
  localparam logic [2:0] S_TRAP_SAVE = 3'(ST_TRAP_SAVE);
  localparam logic [2:0] S_TRAP_JUMP = 3'(ST_TRAP_JUMP);
  localparam logic [2:0] S_MRET_JUMP = 3'(ST_MRET_JUMP);

  logic [6:0]  opcode_s;
  logic [2:0]  funct3_s;
  logic [11:0] imm_s;
  logic [4:0]  rs1_idx_s;
  logic [4:0]  rd_idx_s;
  logic        irq_take_s;
  logic        unused_s;

  logic [2:0]  next_d;
  logic [31:0] cause_d;
  logic [1:0]  op_d;

  logic [2:0]  state_q;
  logic [11:0] addr_q;
  logic [31:0] src_q;
  logic        src_zero_q;
  logic [4:0]  rd_q;
  logic [31:0] pc_q;
  logic [31:0] cause_q;
  logic [1:0]  op_q;

  logic [31:0] alu_wdata_s;
  logic        alu_we_s;

  assign opcode_s  = bus.inst[6:0];
  assign rd_idx_s  = bus.inst[11:7];
  assign funct3_s  = bus.inst[14:12];
  assign rs1_idx_s = bus.inst[19:15];
  assign imm_s     = bus.inst[31:20];

`ifdef CSR_TRAP_IRQ_EN
  logic [1:0] irq_sync_q;

  // Two-flop synchronizer for the asynchronous interrupt level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq_sync_q <= 2'b00;
    end else begin
      irq_sync_q <= {irq_sync_q[0], bus.irq};
    end
  end

  assign irq_take_s = irq_sync_q[1] & bus.mstatus_mie & bus.inst_valid;
  assign unused_s   = ^bus.mtvec_in[1:0];
`else
  assign irq_take_s = 1'b0;
  assign unused_s   = ^{bus.irq, bus.mstatus_mie, bus.mtvec_in[1:0]};
`endif

  // Decode the instruction presented in IDLE; interrupts pre-empt it.
  always_comb begin
    next_d  = S_IDLE;
    cause_d = 32'h0000_0000;
    op_d    = OP_NONE;
    if (irq_take_s) begin
      next_d  = S_TRAP_SAVE;
      cause_d = CAUSE_IRQ_EXT;
    end else if (bus.inst_valid && (opcode_s == OPC_SYSTEM)) begin
      if (bus.inst == INST_UNIMP) begin
        next_d  = S_TRAP_SAVE;
        cause_d = CAUSE_ILLEGAL;
      end else begin
        case (funct3_s)
          F3_PRIV: begin
            case (imm_s)
              IMM_ECALL: begin
                next_d  = S_TRAP_SAVE;
                cause_d = CAUSE_ECALL_M;
              end
              IMM_EBREAK: begin
                next_d  = S_TRAP_SAVE;
                cause_d = CAUSE_BREAK;
              end
              IMM_MRET: next_d = S_MRET_JUMP;
              default: begin
                next_d  = S_TRAP_SAVE;
                cause_d = CAUSE_ILLEGAL;
              end
            endcase
          end
          F3_CSRRW, F3_CSRRWI: op_d = OP_RW;
          F3_CSRRS, F3_CSRRSI: op_d = OP_RS;
          F3_CSRRC, F3_CSRRCI: op_d = OP_RC;
          default: begin
            next_d  = S_TRAP_SAVE;
            cause_d = CAUSE_ILLEGAL;
          end
        endcase
        if (op_d == OP_NONE) begin
          op_d = OP_NONE;
        end else if (csr_addr_legal(imm_s)) begin
          next_d = S_CSR_WB;
        end else begin
          next_d  = S_TRAP_SAVE;
          cause_d = CAUSE_ILLEGAL;
          op_d    = OP_NONE;
        end
      end
    end else begin
      next_d = S_IDLE;
    end
  end

  // Sequencer state and operands captured on leaving IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      addr_q     <= 12'h000;
      src_q      <= 32'h0000_0000;
      src_zero_q <= 1'b0;
      rd_q       <= 5'd0;
      pc_q       <= 32'h0000_0000;
      cause_q    <= 32'h0000_0000;
      op_q       <= OP_NONE;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_q <= next_d;
          if (next_d != S_IDLE) begin
            addr_q     <= imm_s;
            src_q      <= funct3_s[2] ? {27'd0, rs1_idx_s} : bus.rs1_data;
            src_zero_q <= (rs1_idx_s == 5'd0);
            rd_q       <= rd_idx_s;
            pc_q       <= bus.pc;
            cause_q    <= cause_d;
            op_q       <= op_d;
          end
        end
        S_TRAP_SAVE: state_q <= S_TRAP_JUMP;
        default:     state_q <= S_IDLE;
      endcase
    end
  end

  csr_wdata_alu u_alu (
    .op_i           (op_q),
    .addr_i         (addr_q),
    .old_i          (bus.csr_rdata),
    .src_i          (src_q),
    .src_idx_zero_i (src_zero_q),
    .wdata_o        (alu_wdata_s),
    .we_o           (alu_we_s)
  );

  // Per-state output strobes; only the decode cycle looks at live inputs.
  always_comb begin
    bus.csr_raddr      = 12'h000;
    bus.csr_we         = 1'b0;
    bus.csr_waddr      = 12'h000;
    bus.csr_wdata      = 32'h0000_0000;
    bus.trap_set       = 1'b0;
    bus.trap_cause     = 32'h0000_0000;
    bus.trap_epc       = 32'h0000_0000;
    bus.mret_clr       = 1'b0;
    bus.rd_we          = 1'b0;
    bus.rd_addr        = 5'd0;
    bus.rd_wdata       = 32'h0000_0000;
    bus.stall          = 1'b0;
    bus.flush          = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0000_0000;
    case (state_q)
      S_IDLE: begin
        bus.stall = !rst && (next_d != S_IDLE);
        bus.flush = !rst && ((next_d == S_TRAP_SAVE) || (next_d == S_MRET_JUMP));
      end
      S_CSR_WB: begin
        bus.csr_raddr = addr_q;
        if (alu_we_s) begin
          bus.csr_we    = 1'b1;
          bus.csr_waddr = addr_q;
          bus.csr_wdata = alu_wdata_s;
        end else begin
          bus.csr_we    = 1'b0;
        end
        if (rd_q != 5'd0) begin
          bus.rd_we    = 1'b1;
          bus.rd_addr  = rd_q;
          bus.rd_wdata = bus.csr_rdata;
        end else begin
          bus.rd_we    = 1'b0;
        end
      end
      S_TRAP_SAVE: begin
        bus.trap_set   = 1'b1;
        bus.trap_cause = cause_q;
        bus.trap_epc   = pc_q;
        bus.stall      = 1'b1;
      end
      S_TRAP_JUMP: begin
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = {bus.mtvec_in[31:2], 2'b00};
      end
      S_MRET_JUMP: begin
        bus.mret_clr       = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = bus.mepc_in;
      end
      default: begin
        bus.stall = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_csr_trap_ctrl.sv
// Self-checking bench for csr_trap_ctrl: directed plan cases plus randomized
// SYSTEM instructions checked against a per-instruction behavioural model.
module tb_csr_trap_ctrl;

  typedef struct packed {
    logic        stall;
    logic        flush;
    logic        csr_we;
    logic [11:0] csr_waddr;
    logic [31:0] csr_wdata;
    logic [11:0] csr_raddr;
    logic        rd_we;
    logic [4:0]  rd_addr;
    logic [31:0] rd_wdata;
    logic        trap_set;
    logic [31:0] trap_cause;
    logic [31:0] trap_epc;
    logic        mret_clr;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
  } out_t;

  localparam logic [6:0] OPC = 7'b1110011;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  logic [31:0] csr_mstatus;
  logic [31:0] csr_mtvec;
  logic [31:0] csr_mepc;
  logic [31:0] csr_mcause;

  out_t exp_q [0:3];
  out_t obs_q [0:3];
  int   exp_n;

  csr_trap_ctrl_if ifc ();

  csr_trap_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] csr_read(input logic [11:0] a);
    case (a)
      12'h300: return csr_mstatus;
      12'h305: return csr_mtvec;
      12'h341: return csr_mepc;
      12'h342: return csr_mcause;
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  always_comb ifc.csr_rdata = csr_read(ifc.csr_raddr);
  assign ifc.mtvec_in = csr_mtvec;
  assign ifc.mepc_in  = csr_mepc;

  function automatic out_t sample();
    out_t o;
    o.stall          = ifc.stall;
    o.flush          = ifc.flush;
    o.csr_we         = ifc.csr_we;
    o.csr_waddr      = ifc.csr_waddr;
    o.csr_wdata      = ifc.csr_wdata;
    o.csr_raddr      = ifc.csr_raddr;
    o.rd_we          = ifc.rd_we;
    o.rd_addr        = ifc.rd_addr;
    o.rd_wdata       = ifc.rd_wdata;
    o.trap_set       = ifc.trap_set;
    o.trap_cause     = ifc.trap_cause;
    o.trap_epc       = ifc.trap_epc;
    o.mret_clr       = ifc.mret_clr;
    o.redirect_valid = ifc.redirect_valid;
    o.redirect_pc    = ifc.redirect_pc;
    return o;
  endfunction

  // Reference model: classify the instruction, then lay out its cycle trace.
  task automatic predict(input logic [31:0] i, input logic [31:0] r1v,
                         input logic [31:0] p, input logic irq_hit);
    logic [11:0] a;
    logic [2:0]  f3;
    logic [31:0] old, src, nv, cause;
    logic        wr;
    int          kind;
    a = i[31:20];
    f3 = i[14:12];
    cause = 32'h0;
    for (int c = 0; c < 4; c++) exp_q[c] = '0;
    if (irq_hit) begin kind = 1; cause = 32'h8000_000B; end
    else if (i[6:0] != OPC) kind = 0;
    else if (i == 32'hC000_1073) begin kind = 1; cause = 32'h2; end
    else if (f3 == 3'b000) begin
      if (a == 12'h000)      begin kind = 1; cause = 32'hB; end
      else if (a == 12'h001) begin kind = 1; cause = 32'h3; end
      else if (a == 12'h302) kind = 2;
      else                   begin kind = 1; cause = 32'h2; end
    end else if (f3 == 3'b100 || !(a inside {12'h300, 12'h305, 12'h341, 12'h342})) begin
      kind = 1; cause = 32'h2;
    end else kind = 3;
    case (kind)
      0: exp_n = 1;
      1: begin
        exp_n = 3;
        exp_q[0].stall = 1'b1; exp_q[0].flush = 1'b1;
        exp_q[1].trap_set = 1'b1; exp_q[1].trap_cause = cause;
        exp_q[1].trap_epc = p; exp_q[1].stall = 1'b1;
        exp_q[2].redirect_valid = 1'b1; exp_q[2].redirect_pc = csr_mtvec & 32'hFFFF_FFFC;
      end
      2: begin
        exp_n = 2;
        exp_q[0].stall = 1'b1; exp_q[0].flush = 1'b1;
        exp_q[1].mret_clr = 1'b1; exp_q[1].redirect_valid = 1'b1;
        exp_q[1].redirect_pc = csr_mepc;
      end
      default: begin
        exp_n = 2;
        old = csr_read(a);
        src = f3[2] ? {27'd0, i[19:15]} : r1v;
        if (f3[1:0] == 2'b01)      nv = src;
        else if (f3[1:0] == 2'b10) nv = old | src;
        else                       nv = old & ~src;
        wr = ((f3[1:0] == 2'b01) || (i[19:15] != 5'd0)) && (a != 12'h342);
        exp_q[0].stall = 1'b1;
        exp_q[1].csr_raddr = a;
        if (wr) begin
          exp_q[1].csr_we = 1'b1; exp_q[1].csr_waddr = a; exp_q[1].csr_wdata = nv;
        end
        if (i[11:7] != 5'd0) begin
          exp_q[1].rd_we = 1'b1; exp_q[1].rd_addr = i[11:7]; exp_q[1].rd_wdata = old;
        end
      end
    endcase
  endtask

  // Present the instruction for one cycle, then junk that must be ignored.
  task automatic run_inst(input logic [31:0] i, input logic [31:0] r1v,
                          input logic [31:0] p, input int n);
    for (int c = 0; c < n; c++) begin
      @(posedge clk); #1;
      if (c == 0) begin
        ifc.inst_valid = 1'b1; ifc.inst = i; ifc.rs1_data = r1v; ifc.pc = p;
      end else begin
        ifc.inst_valid = 1'($urandom_range(0, 1));
        ifc.inst = {$urandom} | 32'h0000_0073;
        ifc.rs1_data = $urandom; ifc.pc = $urandom;
      end
      #1;
      obs_q[c] = sample();
    end
  endtask

  task automatic go(input logic [31:0] i, input logic [31:0] r1v,
                    input logic [31:0] p, input logic irq_hit);
    predict(i, r1v, p, irq_hit);
    run_inst(i, r1v, p, exp_n);
  endtask

  task automatic idle(input int n);
    for (int c = 0; c < n; c++) begin
      @(posedge clk); #1;
      ifc.inst_valid = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ifc.inst_valid = 1'b1; ifc.inst = 32'h0000_0073; ifc.pc = 32'h0;
    ifc.rs1_data = 32'h0; ifc.irq = 1'b0; ifc.mstatus_mie = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (sample() !== out_t'(0)) begin
      errors++; $display("FAIL reset_outputs got=%h want=0", sample());
    end
    @(posedge clk); #1;
    ifc.inst_valid = 1'b0;
    rst = 1'b0;
    #1;
    checks++;
    if (sample() !== out_t'(0)) begin
      errors++; $display("FAIL reset_release got=%h want=0", sample());
    end
  endtask

  task automatic test_csr_ops();
    csr_mtvec = 32'h0; csr_mstatus = 32'h0000_1888;
    go({12'h305, 5'd6, 3'b001, 5'd5, OPC}, 32'h0000_0100, 32'h0000_0020, 1'b0);
    for (int c = 0; c < exp_n; c++) begin
      checks++;
      if (obs_q[c] !== exp_q[c]) begin
        errors++; $display("FAIL csrrw_mtvec cyc%0d got=%h want=%h", c, obs_q[c], exp_q[c]);
      end
    end
    checks++;
    if ({obs_q[0].stall, obs_q[1].stall, obs_q[1].csr_we, obs_q[1].csr_waddr,
         obs_q[1].csr_wdata, obs_q[1].rd_we, obs_q[1].rd_addr, obs_q[1].rd_wdata}
        !== {1'b1, 1'b0, 1'b1, 12'h305, 32'h100, 1'b1, 5'd5, 32'h0}) begin
      errors++; $display("FAIL csrrw_plan got we=%b waddr=%h wdata=%h rd=%0d want we=1 waddr=305 wdata=100 rd=5",
                         obs_q[1].csr_we, obs_q[1].csr_waddr, obs_q[1].csr_wdata, obs_q[1].rd_addr);
    end
    go({12'h300, 5'd0, 3'b010, 5'd7, OPC}, 32'hFFFF_FFFF, 32'h0000_0024, 1'b0);
    for (int c = 0; c < exp_n; c++) begin
      checks++;
      if (obs_q[c] !== exp_q[c]) begin
        errors++; $display("FAIL csrrs_x0 cyc%0d got=%h want=%h", c, obs_q[c], exp_q[c]);
      end
    end
    checks++;
    if ({obs_q[1].csr_we, obs_q[1].rd_wdata} !== {1'b0, 32'h0000_1888}) begin
      errors++; $display("FAIL csrrs_x0_plan got we=%b rd_wdata=%h want we=0 rd_wdata=1888",
                         obs_q[1].csr_we, obs_q[1].rd_wdata);
    end
  endtask

  task automatic test_traps();
    logic [31:0] tbl_inst [0:4];
    logic [31:0] tbl_pc   [0:4];
    tbl_inst[0] = 32'h0000_0073; tbl_pc[0] = 32'h40;
    tbl_inst[1] = 32'hC000_1073; tbl_pc[1] = 32'h80;
    tbl_inst[2] = 32'h3020_0073; tbl_pc[2] = 32'h90;
    tbl_inst[3] = {12'h7C0, 5'd2, 3'b001, 5'd1, OPC}; tbl_pc[3] = 32'hA0;
    tbl_inst[4] = 32'h0010_0073; tbl_pc[4] = 32'hB0;
    csr_mtvec = 32'h0000_0201; csr_mepc = 32'h0000_0084;
    for (int k = 0; k < 5; k++) begin
      go(tbl_inst[k], 32'h1234_5678, tbl_pc[k], 1'b0);
      for (int c = 0; c < exp_n; c++) begin
        checks++;
        if (obs_q[c] !== exp_q[c]) begin
          errors++; $display("FAIL trap_case%0d cyc%0d got=%h want=%h", k, c, obs_q[c], exp_q[c]);
        end
      end
      if (k == 0) begin
        checks++;
        if ({obs_q[1].trap_cause, obs_q[1].trap_epc, obs_q[2].redirect_pc}
            !== {32'hB, 32'h40, 32'h200}) begin
          errors++; $display("FAIL ecall_plan got cause=%h epc=%h target=%h want B 40 200",
                             obs_q[1].trap_cause, obs_q[1].trap_epc, obs_q[2].redirect_pc);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    csr_mtvec = 32'h0000_0300;
    @(posedge clk); #1;
    ifc.inst_valid = 1'b1; ifc.inst = 32'h0000_0073; ifc.pc = 32'h44;
    @(posedge clk); #1;
    ifc.inst_valid = 1'b0;
    #1;
    checks++;
    if (ifc.trap_set !== 1'b1) begin
      errors++; $display("FAIL mid_reset_setup got trap_set=%b want 1", ifc.trap_set);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (sample() !== out_t'(0)) begin
      errors++; $display("FAIL mid_reset_async got=%h want=0", sample());
    end
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #2;
      checks++;
      if (sample() !== out_t'(0)) begin
        errors++; $display("FAIL mid_reset_hold cyc%0d got=%h want=0", c, sample());
      end
    end
    rst = 1'b0;
    @(posedge clk); #2;
    checks++;
    if (sample() !== out_t'(0)) begin
      errors++; $display("FAIL mid_reset_after got=%h want=0", sample());
    end
  endtask

  task automatic test_irq();
    logic hit;
`ifdef CSR_TRAP_IRQ_EN
    hit = 1'b1;
`else
    hit = 1'b0;
`endif
    csr_mtvec = 32'h0000_0400; csr_mstatus = 32'h8;
    ifc.irq = 1'b1; ifc.mstatus_mie = 1'b1;
    idle(3);
    go({12'h300, 5'd3, 3'b001, 5'd4, OPC}, 32'h55, 32'h0000_0010, hit);
    for (int c = 0; c < exp_n; c++) begin
      checks++;
      if (obs_q[c] !== exp_q[c]) begin
        errors++; $display("FAIL irq_mie1 cyc%0d got=%h want=%h", c, obs_q[c], exp_q[c]);
      end
    end
    ifc.mstatus_mie = 1'b0;
    go(32'h0010_0073, 32'h0, 32'h0000_0014, 1'b0);
    for (int c = 0; c < exp_n; c++) begin
      checks++;
      if (obs_q[c] !== exp_q[c]) begin
        errors++; $display("FAIL irq_mie0 cyc%0d got=%h want=%h", c, obs_q[c], exp_q[c]);
      end
    end
    ifc.irq = 1'b0;
    idle(3);
  endtask

  task automatic test_random();
    logic [31:0] ins;
    logic [11:0] a;
    logic [4:0]  r1, rd;
    for (int n = 0; n < 150; n++) begin
      csr_mstatus = $urandom; csr_mtvec = $urandom;
      csr_mepc = $urandom; csr_mcause = $urandom;
      r1 = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      rd = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      case ($urandom_range(0, 4))
        0: a = 12'h300;
        1: a = 12'h305;
        2: a = 12'h341;
        3: a = 12'h342;
        default: a = 12'($urandom);
      endcase
      case ($urandom_range(0, 11))
        0: ins = 32'hC000_1073;
        1: begin ins = $urandom; ins[6:0] = 7'b0110011; end
        2: ins = 32'h0000_0073;
        3: ins = 32'h3020_0073;
        4: ins = 32'h0010_0073;
        default: ins = {a, r1, 3'($urandom), rd, OPC};
      endcase
      go(ins, $urandom, $urandom, 1'b0);
      for (int c = 0; c < exp_n; c++) begin
        checks++;
        if (obs_q[c] !== exp_q[c]) begin
          errors++; $display("FAIL random%0d inst=%h cyc%0d got=%h want=%h", n, ins, c, obs_q[c], exp_q[c]);
        end
      end
    end
  endtask

  initial begin
    errors = 0; checks = 0;
    csr_mstatus = 32'h0; csr_mtvec = 32'h0; csr_mepc = 32'h0; csr_mcause = 32'h0;
    test_reset();
    test_csr_ops();
    test_traps();
    test_reset_mid();
    test_irq();
    test_random();
    idle(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
